// File: rtl/mem_arbiter.sv
// Round-robin two-requester arbiter/sequencer for the single-port negedge memory.
// Optional requester-1 write protection below WPROT_LIMIT: define MEM_ARB_WPROT_EN.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12
`ifdef MEM_ARB_WPROT_EN
    ,
    parameter logic [ADDRESS_WIDTH-1:0] WPROT_LIMIT = ADDRESS_WIDTH'(12'h100)
`endif
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0,
    input  logic                     we0,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    output logic                     ack0,
    output logic [DATA_WIDTH-1:0]    rdata0,

    input  logic                     req1,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     ack1,
    output logic [DATA_WIDTH-1:0]    rdata1,
`ifdef MEM_ARB_WPROT_EN
    output logic                     err1,
`endif

    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } req_t;

    state_e                   state_q, state_d;
    logic                     gnt_q, gnt_d;
    logic                     last_q, last_d;
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
`ifdef MEM_ARB_WPROT_EN
    logic                     prot_q, prot_d;
    logic                     blocked_c;
`endif

    req_t pl0_c, pl1_c, win_pl_c;
    logic win_c;
    logic any_req_c;
    logic in_access_c;

    // Winner selection: a lone request wins; on contention the one that did not go last.
    always_comb begin
        pl0_c     = '{we: we0, addr: addr0, data: wdata0};
        pl1_c     = '{we: we1, addr: addr1, data: wdata1};
        any_req_c = req0 | req1;
        win_c     = (req0 & req1) ? ~last_q : req1;
        win_pl_c  = win_c ? pl1_c : pl0_c;
`ifdef MEM_ARB_WPROT_EN
        blocked_c = win_c & pl1_c.we & (pl1_c.addr < WPROT_LIMIT);
`endif
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef MEM_ARB_WPROT_EN
        prot_d  = prot_q;
`endif
        case (state_q)
            IDLE: begin
                wen_d = 1'b0;
                if (any_req_c) begin
                    state_d = ACCESS;
                    gnt_d   = win_c;
                    last_d  = win_c;
                    addr_d  = win_pl_c.addr;
                    wdata_d = win_pl_c.data;
`ifdef MEM_ARB_WPROT_EN
                    wen_d   = win_pl_c.we & ~blocked_c;
                    prot_d  = blocked_c;
`else
                    wen_d   = win_pl_c.we;
`endif
                end
            end
            ACCESS: begin
                // Single-cycle access; write enable drops on the way back to IDLE.
                state_d = IDLE;
                wen_d   = 1'b0;
`ifdef MEM_ARB_WPROT_EN
                prot_d  = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                wen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_ARB_WPROT_EN
            prot_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEM_ARB_WPROT_EN
            prot_q  <= prot_d;
`endif
        end
    end

    // Acks are decoded from state/grant and masked while reset is asserted.
    always_comb begin
        in_access_c = (state_q == ACCESS);
        ack0        = ~reset & in_access_c & ~gnt_q;
        ack1        = ~reset & in_access_c &  gnt_q;
        rdata0      = (in_access_c & ~gnt_q) ? mem_dataOut : '0;
        rdata1      = (in_access_c &  gnt_q) ? mem_dataOut : '0;
`ifdef MEM_ARB_WPROT_EN
        err1        = ack1 & prot_q;
`endif
    end

    assign mem_wEn    = wen_q;
    assign mem_addr   = addr_q;
    assign mem_dataIn = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural negedge-clocked memory.
// Build with MEM_ARB_WPROT_EN defined to exercise the write-protect path.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
`ifdef MEM_ARB_WPROT_EN
    logic        err1;
`endif
    logic        mem_wEn;
    logic [11:0] mem_addr;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut = '0;

    logic [31:0] mem [4096];
    logic        bk_we = 1'b0;
    logic [11:0] bk_addr = '0;
    logic [31:0] bk_data = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .ack0        (ack0),
        .rdata0      (rdata0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .ack1        (ack1),
        .rdata1      (rdata1),
`ifdef MEM_ARB_WPROT_EN
        .err1        (err1),
`endif
        .mem_wEn     (mem_wEn),
        .mem_addr    (mem_addr),
        .mem_dataIn  (mem_dataIn),
        .mem_dataOut (mem_dataOut)
    );

    // Memory model: writes when wEn=1, otherwise refreshes dataOut, on negedge.
    always @(negedge clk) begin
        if (bk_we)
            mem[bk_addr] <= bk_data;
        else if (mem_wEn)
            mem[mem_addr] <= mem_dataIn;
        else
            mem_dataOut <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        bk_addr = a;
        bk_data = d;
        bk_we   = 1'b1;
        mid();
        bk_we   = 1'b0;
    endtask

    // One complete handshake; entered just after a posedge with the arbiter idle.
    task automatic access(input int r, input logic we, input logic [11:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        logic exp_err;
        logic exp_wen;
        exp_err = 1'b0;
`ifdef MEM_ARB_WPROT_EN
        exp_err = (r == 1) && we && (a < 12'h100);
`endif
        exp_wen = we & ~exp_err;
        if (r == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        mid();
        chk("pre_ack0", 32'(ack0), 32'd0);
        chk("pre_ack1", 32'(ack1), 32'd0);
        tick();
        mid();
        chk($sformatf("ack%0d", r), 32'(r == 0 ? ack0 : ack1), 32'd1);
        chk("other_ack", 32'(r == 0 ? ack1 : ack0), 32'd0);
        chk("acc_wen", 32'(mem_wEn), 32'(exp_wen));
        chk("acc_addr", 32'(mem_addr), 32'(a));
        if (we)
            chk("acc_din", mem_dataIn, d);
        else begin
            chk($sformatf("rdata%0d", r), r == 0 ? rdata0 : rdata1, exp_rd);
            chk("other_rdata", r == 0 ? rdata1 : rdata0, 32'd0);
        end
`ifdef MEM_ARB_WPROT_EN
        chk("err1", 32'(err1), 32'(exp_err));
`endif
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        mid();
        chk("post_ack0", 32'(ack0), 32'd0);
        chk("post_ack1", 32'(ack1), 32'd0);
        chk("post_wen", 32'(mem_wEn), 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        preload(12'h010, 32'hDEADBEEF);
        preload(12'h050, 32'h11111111);
        tick();
        tick();

        // Reset state
        mid();
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_wen", 32'(mem_wEn), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_din", mem_dataIn, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single read, then write/read through requester 1
        access(0, 1'b0, 12'h010, 32'd0, 32'hDEADBEEF);
        access(1, 1'b1, 12'h200, 32'h12345678, 32'd0);
        chk("idle_addr_hold", 32'(mem_addr), 32'h200);
        access(1, 1'b0, 12'h200, 32'd0, 32'h12345678);

        // Contention straight after reset: requester 0 first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h200;
        mid();
        chk("ct_idle_ack0", 32'(ack0), 32'd0);
        chk("ct_idle_ack1", 32'(ack1), 32'd0);
        tick();
        mid();
        chk("ct_first_ack0", 32'(ack0), 32'd1);
        chk("ct_first_ack1", 32'(ack1), 32'd0);
        chk("ct_first_rd0", rdata0, 32'hDEADBEEF);
        chk("ct_first_rd1", rdata1, 32'd0);
        tick();
        req0 = 1'b0;
        mid();
        chk("ct_gap_ack0", 32'(ack0), 32'd0);
        chk("ct_gap_ack1", 32'(ack1), 32'd0);
        tick();
        mid();
        chk("ct_second_ack1", 32'(ack1), 32'd1);
        chk("ct_second_ack0", 32'(ack0), 32'd0);
        chk("ct_second_rd1", rdata1, 32'h12345678);
        tick();

        // Both keep requesting: grants alternate 0,1,0,1 with idle cycles between
        req0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk($sformatf("alt_ack0_%0d", k), 32'(ack0), 32'((k == 1) || (k == 5)));
            chk($sformatf("alt_ack1_%0d", k), 32'(ack1), 32'((k == 3) || (k == 7)));
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        mid();
        chk("alt_end_ack1", 32'(ack1), 32'd0);
        tick();

        // Back-to-back single requester: ack every other cycle
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk($sformatf("b2b_ack0_%0d", k), 32'(ack0), 32'(k % 2));
            chk($sformatf("b2b_ack1_%0d", k), 32'(ack1), 32'd0);
            if (k % 2 == 1)
                chk($sformatf("b2b_rd0_%0d", k), rdata0, 32'hDEADBEEF);
            tick();
        end
        req0 = 1'b0;
        mid();
        tick();

        // Reset during a write access
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h300; wdata0 = 32'hAAAA5555;
        tick();
        reset = 1'b1;
        mid();
        chk("rma_ack0", 32'(ack0), 32'd0);
        chk("rma_wen_before", 32'(mem_wEn), 32'd1);
`ifdef MEM_ARB_WPROT_EN
        chk("rma_err1", 32'(err1), 32'd0);
`endif
        tick();
        reset = 1'b0;
        req0 = 1'b0;
        mid();
        chk("rma_wen_after", 32'(mem_wEn), 32'd0);
        chk("rma_ack0_after", 32'(ack0), 32'd0);
        chk("rma_addr_after", 32'(mem_addr), 32'd0);
        tick();
        access(0, 1'b0, 12'h010, 32'd0, 32'hDEADBEEF);

`ifdef MEM_ARB_WPROT_EN
        access(1, 1'b1, 12'h050, 32'h0000CAFE, 32'd0);
        access(1, 1'b0, 12'h050, 32'd0, 32'h11111111);
        access(0, 1'b1, 12'h050, 32'h0000CAFE, 32'd0);
        access(1, 1'b0, 12'h050, 32'd0, 32'h0000CAFE);
`else
        access(1, 1'b1, 12'h050, 32'h0000CAFE, 32'd0);
        access(1, 1'b0, 12'h050, 32'd0, 32'h0000CAFE);
        access(0, 1'b1, 12'h050, 32'h0BADF00D, 32'd0);
        access(0, 1'b0, 12'h050, 32'd0, 32'h0BADF00D);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
